mcpu6_bus_responder: RTL and testbench
======================================

// Module: mcpu6_bus_responder
// PURPOSE
// - Memory/host side of the 6-bit MCPU pin interface. Generates the CPU clock and reset,
//   demultiplexes the CPU's time-shared output bus (address during cpu_clk high, accumulator
//   during cpu_clk low), serves a 16x6 program/data RAM on cpu_din and captures stores.
// - A host loads the RAM over a valid/ready port while the CPU is held in reset.
// PARAMETERS
// - DIV     2   sys clocks per cpu_clk half-period; legal range >= 2
// PORTS
// - clk        in   1   system clock; all state updates on its rising edge
// - rst        in   1   synchronous, active-high reset
// - ld_valid   in   1   host load request
// - ld_ready   out  1   load accepted when ld_valid & ld_ready
// - ld_addr    in   4   RAM word address for the load
// - ld_data    in   6   RAM word data for the load
// - run        in   1   level/pulse: leave LOAD and start the CPU
// - stop       in   1   return to LOAD; RAM contents are preserved
// - cpu_clk    out  1   CPU clock (maps to CPU io_in[0])
// - cpu_rst_n  out  1   CPU reset, active-low (maps to CPU io_in[1])
// - cpu_din    out  6   RAM read data to CPU (maps to CPU io_in[7:2])
// - cpu_dout   in   6   CPU muxed bus (CPU io_out[7:2])
// - cpu_we_n   in   1   CPU store strobe, active-low (CPU io_out[1])
// - running    out  1   1 in RUN state
// - cpu_cycles out  16  cpu_clk rising edges counted in RUN, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset: state LOAD, cpu_clk=0, phase=0, cpu_rst_n=0, cpu_din=0, addr_lat=0, RAM all 0,
//   ld_ready=1, running=0, cpu_cycles=0, seen_rise=0.
// - Clock gen: phase counts 0..DIV-1 and runs in every state. At phase==DIV-1: phase->0,
//   cpu_clk toggles. Rising edge of cpu_clk = cycle in which it goes 0->1.
// - Address capture: on the cycle with cpu_clk==1 && phase==DIV-1:
//   addr_lat <= cpu_dout[3:0] and cpu_din <= RAM[cpu_dout[3:0]]. cpu_din holds for the whole
//   low phase and the following high phase, and is stable at the next cpu_clk rise.
// - Store: on the cycle with cpu_clk==0 && phase==DIV-1 && state==RUN && cpu_we_n==0:
//   RAM[addr_lat] <= cpu_dout. cpu_we_n is ignored outside RUN and outside that cycle.
// - FSM: LOAD -> RELEASE -> RUN -> LOAD.
//   LOAD: ld_ready=1, cpu_rst_n=0. ld_valid writes RAM[ld_addr] <= ld_data in the same
//   cycle. Any cpu_clk rise sets seen_rise. run=1 moves to RELEASE. If ld_valid and run
//   occur in the same cycle, the load is performed and the transition is taken.
//   RELEASE: ld_ready=0, cpu_rst_n=0. Wait for seen_rise==1 and a cpu_clk 1->0 transition.
//   In that cycle set cpu_rst_n=1, clear cpu_cycles, and enter RUN.
//   RUN: running=1, ld_ready=0, ld_valid is ignored. Each cpu_clk rise increments
//   cpu_cycles (saturating). stop=1 moves to LOAD, with cpu_rst_n=0 from the next cycle and
//   seen_rise cleared. If run and stop are both high in RUN, stop wins. stop is ignored
//   in LOAD and RELEASE.
// - Mid-operation reset: rst dominates everything. It returns to the reset values,
//   including clearing the RAM, in the next cycle.
// - Widths: RAM 16 words x 6 bits. Addresses use cpu_dout[3:0] only; cpu_dout[5:4] are
//   ignored during the address phase. No arithmetic beyond the counters.
// TESTING
// - Reset, DIV=2: cpu_clk toggles every 2 clk cycles; cpu_rst_n=0, ld_ready=1, cpu_din=0.
// - Load word 0x2A to addr 5, then a CPU-model bus with address 5 in the high phase:
//   cpu_din=0x2A at the next cpu_clk rise.
// - run with seen_rise=1: cpu_rst_n rises exactly on a cpu_clk fall; cpu_cycles=0 then counts.
// - Program via the real CPU: mem[0]=6'h0E (NOR 14), mem[14]=0, mem[1]=6'h2F (STA 15),
//   mem[2]=6'h32 (JCC 2). Run 20 cpu cycles -> RAM[15]=6'h3F; the CPU loops at pc 2.
// - stop mid-RUN: cpu_rst_n=0 next cycle; RAM[15] still 6'h3F; ld_ready=1.
//   run+stop together in RUN -> LOAD.
// - Store strobe outside RUN (cpu_we_n=0 forced in LOAD) -> no RAM change. rst during RUN
//   -> all RAM words read 0.

Source files
------------

// File: rtl/mcpu6_bus_responder.sv
// rtl/mcpu6_bus_responder.sv - host/memory side of the 6-bit MCPU pin interface
// Generates cpu_clk/cpu_rst_n, demuxes the CPU bus, serves a 16x6 RAM and captures stores.
module mcpu6_bus_responder #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_addr,
  input  logic [5:0]  ld_data,
  input  logic        run,
  input  logic        stop,
  output logic        cpu_clk,
  output logic        cpu_rst_n,
  output logic [5:0]  cpu_din,
  input  logic [5:0]  cpu_dout,
  input  logic        cpu_we_n,
  output logic        running,
  output logic [15:0] cpu_cycles
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t        state, state_next;
  logic [PW-1:0] phase;
  logic [3:0]    addr_lat;
  logic          seen_rise;
  logic [5:0]    ram [16];
  logic          tick, rise, fall;

  // rise/fall mark the sys cycle whose edge flips cpu_clk
  assign tick = (phase == PW'(DIV - 1));
  assign rise = tick & ~cpu_clk;
  assign fall = tick & cpu_clk;

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    running    = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (run) state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (seen_rise && fall) state_next = S_RUN;
      end
      S_RUN: begin
        running = 1'b1;
        if (stop) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      phase      <= '0;
      cpu_clk    <= 1'b0;
      cpu_rst_n  <= 1'b0;
      cpu_din    <= '0;
      addr_lat   <= '0;
      seen_rise  <= 1'b0;
      cpu_cycles <= '0;
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      state <= state_next;

      if (tick) begin
        phase   <= '0;
        cpu_clk <= ~cpu_clk;
      end else begin
        phase <= phase + 1'b1;
      end

      // End of the high phase: latch the address and fetch its word for the next rise
      if (fall) begin
        addr_lat <= cpu_dout[3:0];
        cpu_din  <= ram[cpu_dout[3:0]];
      end

      if (rise && state == S_RUN && !cpu_we_n) ram[addr_lat] <= cpu_dout;

      if (state == S_LOAD && ld_valid) ram[ld_addr] <= ld_data;

      case (state)
        S_LOAD: begin
          if (rise) seen_rise <= 1'b1;
        end
        S_RELEASE: begin
          // Keep collecting rises here too so a run issued before any rise cannot stall
          if (rise) seen_rise <= 1'b1;
          if (seen_rise && fall) begin
            cpu_rst_n  <= 1'b1;
            cpu_cycles <= '0;
          end
        end
        S_RUN: begin
          if (rise && cpu_cycles != 16'hFFFF) cpu_cycles <= cpu_cycles + 16'd1;
          if (stop) begin
            cpu_rst_n <= 1'b0;
            seen_rise <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu6_bus_responder.sv
// tb/tb_mcpu6_bus_responder.sv - directed bench for mcpu6_bus_responder
// Contains a small MCPU model (NOR/ADD/STA/JCC) driving the muxed pin bus.
module tb_mcpu6_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [3:0]  ld_addr = 4'd0;
  logic [5:0]  ld_data = 6'd0;
  logic        run = 1'b0;
  logic        stop = 1'b0;
  logic        cpu_clk;
  logic        cpu_rst_n;
  logic [5:0]  cpu_din;
  logic [5:0]  cpu_dout;
  logic        cpu_we_n;
  logic        running;
  logic [15:0] cpu_cycles;

  logic        use_model = 1'b0;
  logic [5:0]  tb_dout = 6'd0;
  logic        tb_we_n = 1'b1;

  logic [3:0]  m_pc = 4'd0;
  logic [3:0]  m_adreg = 4'd0;
  logic [5:0]  m_acc = 6'd0;
  logic [5:0]  m_ir = 6'd0;
  logic        m_carry = 1'b0;
  logic        m_st = 1'b0;
  logic        m_we = 1'b0;

  int checks = 0;
  int errors = 0;

  mcpu6_bus_responder #(.DIV(2)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .run(run), .stop(stop), .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_we_n(cpu_we_n), .running(running),
    .cpu_cycles(cpu_cycles)
  );

  always #5 clk = ~clk;

  assign cpu_dout = use_model ? (cpu_clk ? {2'b00, m_adreg} : m_acc) : tb_dout;
  assign cpu_we_n = use_model ? ~m_we : tb_we_n;

  // CPU model: fetch/execute, address shown while cpu_clk is high, accumulator while low
  always @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      m_pc <= 4'd0; m_adreg <= 4'd0; m_acc <= 6'd0; m_ir <= 6'd0;
      m_carry <= 1'b0; m_st <= 1'b0; m_we <= 1'b0;
    end else if (!m_st) begin
      m_ir <= cpu_din;
      m_we <= 1'b0;
      case (cpu_din[5:4])
        2'b11: begin
          if (!m_carry) begin
            m_pc <= cpu_din[3:0]; m_adreg <= cpu_din[3:0];
          end else begin
            m_carry <= 1'b0; m_pc <= m_pc + 4'd1; m_adreg <= m_pc + 4'd1;
          end
        end
        2'b10: begin
          m_pc <= m_pc + 4'd1; m_adreg <= cpu_din[3:0]; m_we <= 1'b1; m_st <= 1'b1;
        end
        default: begin
          m_pc <= m_pc + 4'd1; m_adreg <= cpu_din[3:0]; m_st <= 1'b1;
        end
      endcase
    end else begin
      case (m_ir[5:4])
        2'b00: m_acc <= ~(m_acc | cpu_din);
        2'b01: {m_carry, m_acc} <= {1'b0, m_acc} + {1'b0, cpu_din};
        default: ;
      endcase
      m_we <= 1'b0; m_adreg <= m_pc; m_st <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise();
    logic prev;
    bit   got;
    got  = 1'b0;
    prev = cpu_clk;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      if (cpu_clk === 1'b1 && prev === 1'b0) got = 1'b1;
      prev = cpu_clk;
    end
    if (!got) check("wait_rise_timeout", 16'd0, 16'd1);
  endtask

  task automatic read_ram(input logic [5:0] a, output logic [5:0] d);
    tb_dout = a;
    wait_rise();
    wait_rise();
    d = cpu_din;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [5:0] d);
    ld_addr = a; ld_data = d; ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic wait_running();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 32 && !got; i++) begin
      @(posedge clk); #1;
      if (running === 1'b1) got = 1'b1;
    end
    check("wait_running", 16'(got), 16'd1);
  endtask

  initial begin
    logic [5:0] d;
    logic [3:0] clk_seq;
    logic       pclk;
    bit         rel;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_clk", 16'(cpu_clk), 16'd0);
    check("rst_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
    check("rst_ld_ready", 16'(ld_ready), 16'd1);
    check("rst_cpu_din", 16'(cpu_din), 16'd0);
    check("rst_running", 16'(running), 16'd0);
    check("rst_cpu_cycles", cpu_cycles, 16'd0);
    rst = 1'b0;

    clk_seq = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("clkgen", 16'(cpu_clk), 16'(clk_seq[i]));
    end
    check("load_cpu_rst_n", 16'(cpu_rst_n), 16'd0);

    load_word(4'd5, 6'h2A);
    read_ram(6'h05, d);
    check("ram5_read", 16'(d), 16'h2A);
    read_ram(6'h35, d);
    check("ram5_hi_bits_ignored", 16'(d), 16'h2A);
    read_ram(6'h04, d);
    check("ram4_zero", 16'(d), 16'h00);

    load_word(4'd0, 6'h0E);
    load_word(4'd1, 6'h2F);
    load_word(4'd2, 6'h32);
    load_word(4'd14, 6'h00);
    use_model = 1'b1;
    ld_addr = 4'd3; ld_data = 6'h15; ld_valid = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0; run = 1'b0;
    check("release_ld_ready", 16'(ld_ready), 16'd0);
    check("release_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
    check("release_running", 16'(running), 16'd0);

    rel = 1'b0;
    pclk = 1'b0;
    for (int i = 0; i < 32 && !rel; i++) begin
      pclk = cpu_clk;
      @(posedge clk); #1;
      if (cpu_rst_n === 1'b1) rel = 1'b1;
    end
    check("release_seen", 16'(rel), 16'd1);
    check("release_prev_clk_high", 16'(pclk), 16'd1);
    check("release_on_fall", 16'(cpu_clk), 16'd0);
    check("run_entry_cycles", cpu_cycles, 16'd0);
    check("run_running", 16'(running), 16'd1);

    repeat (20) wait_rise();
    check("cycles_20", cpu_cycles, 16'd20);
    check("model_pc_loop", 16'(m_pc), 16'd2);
    check("model_acc", 16'(m_acc), 16'h3F);

    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
    check("stop_ld_ready", 16'(ld_ready), 16'd1);
    check("stop_running", 16'(running), 16'd0);
    use_model = 1'b0;
    read_ram(6'h0F, d);
    check("ram15_stored", 16'(d), 16'h3F);
    read_ram(6'h03, d);
    check("ram3_load_with_run", 16'(d), 16'h15);
    read_ram(6'h0E, d);
    check("ram14_untouched", 16'(d), 16'h00);

    tb_dout = 6'h0F; tb_we_n = 1'b0;
    repeat (3) wait_rise();
    tb_we_n = 1'b1;
    read_ram(6'h0F, d);
    check("we_outside_run_ignored", 16'(d), 16'h3F);

    use_model = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    wait_running();
    check("rerun_cycles_cleared", cpu_cycles, 16'd0);
    repeat (3) wait_rise();
    check("rerun_cycles_3", cpu_cycles, 16'd3);
    run = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; stop = 1'b0;
    check("runstop_running", 16'(running), 16'd0);
    check("runstop_ld_ready", 16'(ld_ready), 16'd1);
    check("runstop_cpu_rst_n", 16'(cpu_rst_n), 16'd0);

    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    wait_running();
    repeat (4) wait_rise();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_running", 16'(running), 16'd0);
    check("midrst_ld_ready", 16'(ld_ready), 16'd1);
    check("midrst_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
    check("midrst_cycles", cpu_cycles, 16'd0);
    check("midrst_cpu_din", 16'(cpu_din), 16'd0);
    check("midrst_cpu_clk", 16'(cpu_clk), 16'd0);
    use_model = 1'b0;
    read_ram(6'h0F, d);
    check("midrst_ram15", 16'(d), 16'h00);
    read_ram(6'h05, d);
    check("midrst_ram5", 16'(d), 16'h00);
    read_ram(6'h00, d);
    check("midrst_ram0", 16'(d), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
